// File: rtl/weight_pingpong_mem_if.sv
// Bus bundle for the ping-pong weight store: loader stream, page swap
// control and the MAC-side read port.
interface weight_pingpong_mem_if #(
  parameter int N_WEIGHT   = 256,
  parameter int DATA_WIDTH = 16
);
  localparam int AW = $clog2(N_WEIGHT);

  logic                  load_start;
  logic [DATA_WIDTH-1:0] win;
  logic                  win_valid;
  logic                  win_ready;
  logic                  load_done;
  logic                  swap;
  logic                  swap_err;
  logic                  act_valid;
  logic                  page_sel;
  logic                  ren;
  logic [AW-1:0]         radd;
  logic [DATA_WIDTH-1:0] wout;
  logic                  wout_valid;

  modport master (
    output load_start, win, win_valid, swap, ren, radd,
    input  win_ready, load_done, swap_err, act_valid, page_sel, wout, wout_valid
  );

  modport slave (
    input  load_start, win, win_valid, swap, ren, radd,
    output win_ready, load_done, swap_err, act_valid, page_sel, wout, wout_valid
  );
endinterface

// File: rtl/weight_pingpong_mem.sv
// Double-buffered weight store: the loader fills the shadow page while the
// MAC array reads the active page; a swap exchanges them once the shadow
// page holds a complete set.
module weight_pingpong_mem #(
  parameter int N_WEIGHT   = 256,
  parameter int DATA_WIDTH = 16,
  parameter int READ_LAT   = 1
) (
  input logic                  clk,
  input logic                  rst,
  weight_pingpong_mem_if.slave bus
);
  localparam int AW = $clog2(N_WEIGHT);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_WEIGHT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FULL
  } state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         wptr_q, wptr_d;
  logic                  page_sel_q, page_sel_d;
  logic                  act_valid_q, act_valid_d;
  logic                  load_done_q, load_done_d;
  logic                  swap_err_q, swap_err_d;
  logic                  we;
  logic [AW:0]           waddr;

  logic [DATA_WIDTH-1:0] mem [2*N_WEIGHT];

  logic [DATA_WIDTH-1:0] rd1_q, rd1_d;
  logic                  rv1_q, rv1_d;

  // Load FSM next-state, write strobe and swap handling
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    page_sel_d  = page_sel_q;
    act_valid_d = act_valid_q;
    load_done_d = 1'b0;
    swap_err_d  = 1'b0;
    we          = 1'b0;
    waddr       = {~page_sel_q, wptr_q};
    case (state_q)
      S_IDLE: begin
        if (bus.swap) swap_err_d = 1'b1;
        if (bus.load_start) begin
          state_d = S_LOAD;
          wptr_d  = '0;
        end
      end
      S_LOAD: begin
        if (bus.swap) swap_err_d = 1'b1;
        // a restart wins over the word offered in the same cycle
        if (bus.load_start) begin
          wptr_d = '0;
        end else if (bus.win_valid) begin
          we = 1'b1;
          if (wptr_q == LAST_IDX) begin
            state_d     = S_FULL;
            wptr_d      = '0;
            load_done_d = 1'b1;
          end else begin
            wptr_d = wptr_q + 1'b1;
          end
        end
      end
      S_FULL: begin
        if (bus.swap) begin
          page_sel_d  = ~page_sel_q;
          act_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      page_sel_q  <= 1'b0;
      act_valid_q <= 1'b0;
      load_done_q <= 1'b0;
      swap_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      page_sel_q  <= page_sel_d;
      act_valid_q <= act_valid_d;
      load_done_q <= load_done_d;
      swap_err_q  <= swap_err_d;
    end
  end

  // Weight array write port (contents are never reset)
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= bus.win;
  end

  // First read stage: sample the active page as seen before any same-cycle swap
  always_comb begin
    rd1_d = rd1_q;
    if (bus.ren) rd1_d = mem[{page_sel_q, bus.radd}];
    rv1_d = bus.ren & act_valid_q;
  end

  // First read stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd1_q <= '0;
      rv1_q <= 1'b0;
    end else begin
      rd1_q <= rd1_d;
      rv1_q <= rv1_d;
    end
  end

  if (READ_LAT == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] rd2_q, rd2_d;
    logic                  rv2_q, rv2_d;
    logic                  ren1_q, ren1_d;

    // Output register only refreshes when a read is emerging from stage one
    always_comb begin
      ren1_d = bus.ren;
      rd2_d  = ren1_q ? rd1_q : rd2_q;
      rv2_d  = rv1_q;
    end

    // Second read stage registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ren1_q <= 1'b0;
        rd2_q  <= '0;
        rv2_q  <= 1'b0;
      end else begin
        ren1_q <= ren1_d;
        rd2_q  <= rd2_d;
        rv2_q  <= rv2_d;
      end
    end

    assign bus.wout       = rd2_q;
    assign bus.wout_valid = rv2_q;
  end else begin : g_lat1
    assign bus.wout       = rd1_q;
    assign bus.wout_valid = rv1_q;
  end

  if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
    $error("weight_pingpong_mem: READ_LAT must be 1 or 2");
  end

  assign bus.win_ready = (state_q == S_LOAD);
  assign bus.load_done = load_done_q;
  assign bus.swap_err  = swap_err_q;
  assign bus.act_valid = act_valid_q;
  assign bus.page_sel  = page_sel_q;
endmodule

// File: tb/tb_weight_pingpong_mem.sv
// Directed bench for weight_pingpong_mem: one instance per read latency,
// driven identically; read results are checked against a scoreboard queue.
module tb_weight_pingpong_mem;
  localparam int NW = 256;
  localparam int DW = 16;

  logic clk;
  logic rst;

  weight_pingpong_mem_if #(.N_WEIGHT(NW), .DATA_WIDTH(DW)) bus1 ();
  weight_pingpong_mem_if #(.N_WEIGHT(NW), .DATA_WIDTH(DW)) bus2 ();

  assign bus2.load_start = bus1.load_start;
  assign bus2.win        = bus1.win;
  assign bus2.win_valid  = bus1.win_valid;
  assign bus2.swap       = bus1.swap;
  assign bus2.ren        = bus1.ren;
  assign bus2.radd       = bus1.radd;

  weight_pingpong_mem #(.N_WEIGHT(NW), .DATA_WIDTH(DW), .READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .bus(bus1));
  weight_pingpong_mem #(.N_WEIGHT(NW), .DATA_WIDTH(DW), .READ_LAT(2)) u_lat2 (
    .clk(clk), .rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          v;
    logic [15:0] d;
  } rd_t;

  rd_t         q [2][$];
  logic [15:0] mm [0:511];
  int          exp_page;
  bit          exp_act;
  int          cyc;
  bit          mon_en;
  int          vectors;
  int          miscompares;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read-port monitor: pop due entries, otherwise no valid read may appear
  always @(negedge clk) begin
    logic        wv [2];
    logic [15:0] wo [2];
    rd_t         e;
    wv[0] = bus1.wout_valid; wo[0] = bus1.wout;
    wv[1] = bus2.wout_valid; wo[1] = bus2.wout;
    if (mon_en) begin
      for (int i = 0; i < 2; i++) begin
        if (q[i].size() > 0 && q[i][0].due == cyc) begin
          e = q[i].pop_front();
          chk($sformatf("wout_valid_lat%0d", i + 1), 32'(wv[i]), 32'(e.v));
          if (e.v) chk($sformatf("wout_lat%0d", i + 1), 32'(wo[i]), 32'(e.d));
        end else begin
          chk($sformatf("idle_valid_lat%0d", i + 1), 32'(wv[i]), 32'd0);
        end
      end
    end
  end

  task automatic tick();
    int a;
    if (bus1.ren) begin
      a = exp_page * NW + int'(bus1.radd);
      q[0].push_back('{cyc + 1, exp_act, mm[a]});
      q[1].push_back('{cyc + 2, exp_act, mm[a]});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_both(input string tag, input logic a, input logic b, input logic exp);
    chk({tag, "_lat1"}, 32'(a), 32'(exp));
    chk({tag, "_lat2"}, 32'(b), 32'(exp));
  endtask

  task automatic stream(input int n, input int first, input int base, input bit rd);
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = first + k;
      chk_both("win_ready_in_load", bus1.win_ready, bus2.win_ready, 1'b1);
      chk_both("load_done_early", bus1.load_done, bus2.load_done, 1'b0);
      bus1.win       = 16'(base + idx);
      bus1.win_valid = 1'b1;
      if (rd) begin
        bus1.ren  = 1'b1;
        bus1.radd = 8'(idx);
      end
      mm[(1 - exp_page) * NW + idx] = 16'(base + idx);
      tick();
    end
    bus1.win_valid = 1'b0;
    bus1.ren       = 1'b0;
  endtask

  task automatic start_load();
    bus1.load_start = 1'b1;
    tick();
    bus1.load_start = 1'b0;
  endtask

  task automatic full_load(input int base, input bit rd);
    stream(NW, 0, base, rd);
    chk_both("load_done_pulse", bus1.load_done, bus2.load_done, 1'b1);
    chk_both("win_ready_full", bus1.win_ready, bus2.win_ready, 1'b0);
    tick();
    chk_both("load_done_clear", bus1.load_done, bus2.load_done, 1'b0);
  endtask

  task automatic do_swap();
    bus1.swap = 1'b1;
    tick();
    bus1.swap = 1'b0;
    exp_page  = 1 - exp_page;
    exp_act   = 1'b1;
    chk_both("page_sel_swap", bus1.page_sel, bus2.page_sel, exp_page[0]);
    chk_both("act_valid_swap", bus1.act_valid, bus2.act_valid, 1'b1);
    chk_both("swap_err_ok", bus1.swap_err, bus2.swap_err, 1'b0);
  endtask

  task automatic read1(input int a);
    bus1.ren  = 1'b1;
    bus1.radd = 8'(a);
    tick();
    bus1.ren  = 1'b0;
  endtask

  task automatic drain();
    repeat (3) tick();
  endtask

  initial begin
    rst             = 1'b1;
    bus1.load_start = 1'b0;
    bus1.win        = '0;
    bus1.win_valid  = 1'b0;
    bus1.swap       = 1'b0;
    bus1.ren        = 1'b0;
    bus1.radd       = '0;
    exp_page        = 0;
    exp_act         = 1'b0;
    mon_en          = 1'b0;
    vectors         = 0;
    miscompares     = 0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk_both("rst_win_ready", bus1.win_ready, bus2.win_ready, 1'b0);
    chk_both("rst_act_valid", bus1.act_valid, bus2.act_valid, 1'b0);
    chk_both("rst_page_sel", bus1.page_sel, bus2.page_sel, 1'b0);
    chk_both("rst_load_done", bus1.load_done, bus2.load_done, 1'b0);
    chk_both("rst_swap_err", bus1.swap_err, bus2.swap_err, 1'b0);
    chk_both("rst_wout_valid", bus1.wout_valid, bus2.wout_valid, 1'b0);
    chk("rst_wout_lat1", 32'(bus1.wout), 32'd0);
    chk("rst_wout_lat2", 32'(bus2.wout), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // 1: reads with no active page never report valid
    bus1.ren  = 1'b1;
    bus1.radd = 8'd5;
    repeat (4) tick();
    bus1.ren = 1'b0;
    drain();
    chk_both("t1_act_valid", bus1.act_valid, bus2.act_valid, 1'b0);
    chk_both("t1_page_sel", bus1.page_sel, bus2.page_sel, 1'b0);
    bus1.swap = 1'b1;
    tick();
    bus1.swap = 1'b0;
    chk_both("t1_swap_err_idle", bus1.swap_err, bus2.swap_err, 1'b1);
    tick();
    chk_both("t1_swap_err_clear", bus1.swap_err, bus2.swap_err, 1'b0);

    // 2: first full load into page 1, swap, read back
    start_load();
    full_load(0, 1'b0);
    do_swap();
    read1(7);
    drain();

    // 3: load page 0 while reading page 1 every cycle
    start_load();
    full_load(1000, 1'b1);
    do_swap();
    read1(3);
    read1(255);
    read1(0);
    drain();

    // 4: swap during load, restart mid-stream, then a full set
    start_load();
    stream(10, 0, 2000, 1'b0);
    bus1.swap = 1'b1;
    tick();
    bus1.swap = 1'b0;
    chk_both("t4_swap_err", bus1.swap_err, bus2.swap_err, 1'b1);
    chk_both("t4_page_keep", bus1.page_sel, bus2.page_sel, exp_page[0]);
    tick();
    chk_both("t4_swap_err_clear", bus1.swap_err, bus2.swap_err, 1'b0);
    stream(10, 10, 2000, 1'b0);
    bus1.load_start = 1'b1;
    bus1.win        = 16'hdead;
    bus1.win_valid  = 1'b1;
    tick();
    bus1.load_start = 1'b0;
    bus1.win_valid  = 1'b0;
    full_load(3000, 1'b0);
    start_load();
    chk_both("t4_full_ignores_start", bus1.win_ready, bus2.win_ready, 1'b0);
    bus1.load_start = 1'b1;
    do_swap();
    bus1.load_start = 1'b0;
    chk_both("t4_start_dropped", bus1.win_ready, bus2.win_ready, 1'b0);
    read1(0);
    read1(15);
    read1(20);
    read1(255);
    drain();

    // 5: read and swap in the same cycle
    start_load();
    full_load(4000, 1'b0);
    bus1.ren  = 1'b1;
    bus1.radd = 8'd9;
    do_swap();
    bus1.ren  = 1'b1;
    bus1.radd = 8'd9;
    tick();
    bus1.ren = 1'b0;
    drain();

    // 6: reset mid-load, then a clean reload
    start_load();
    stream(100, 0, 4500, 1'b0);
    rst = 1'b1;
    q[0].delete();
    q[1].delete();
    exp_page = 0;
    exp_act  = 1'b0;
    #1;
    chk_both("t6_win_ready", bus1.win_ready, bus2.win_ready, 1'b0);
    chk_both("t6_act_valid", bus1.act_valid, bus2.act_valid, 1'b0);
    chk_both("t6_page_sel", bus1.page_sel, bus2.page_sel, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    start_load();
    full_load(5000, 1'b0);
    do_swap();
    read1(200);
    read1(99);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
